// File: rtl/sketch_bucket_update.sv
// Count-min style sketch bucket: one key + counter per bucket, majority-vote
// replacement (hit increments, conflict decrements, count==1 conflict evicts).
// Two-cycle fixed-latency pipeline with a one-deep write bypass so
// back-to-back same-index inputs never stall.
// Optional build macro: SKETCH_STATS_EN enables the drop/update counters.
module sketch_bucket_update #(
    parameter int unsigned IDX_W = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [95:0]      data_in,
    input  logic             datavalid,
    output logic             ready,
    output logic             outvalid,
    output logic [IDX_W-1:0] out_idx,
    output logic [63:0]      out_key,
    output logic [CNT_W-1:0] out_count,
    output logic             out_hit,
    output logic             out_evict,
    output logic [63:0]      out_old_key,
    output logic [31:0]      drop_cnt,
    output logic [31:0]      upd_cnt
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ---------------------------------------------------------------
    // Input decode
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] in_idx_c;
    logic [63:0]      in_key_c;
    logic             accept_c;
    logic             unused_hash_c;

    assign in_idx_c      = data_in[64 +: IDX_W];
    assign in_key_c      = data_in[63:0];
    assign unused_hash_c = ^data_in[95:64+IDX_W];

    // ---------------------------------------------------------------
    // Init / run FSM
    // ---------------------------------------------------------------
    logic             state_q, state_d;
    logic [IDX_W-1:0] init_addr_q, init_addr_d;
    logic             ready_q, ready_d;

    assign accept_c = datavalid & ready_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            ready_q     <= ready_d;
        end
    end

    // FSM next state: sweep every address once, then run forever
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        ready_d     = ready_q;
        case (state_q)
            ST_INIT: begin
                init_addr_d = init_addr_q + IDX_W'(1);
                if (init_addr_q == {IDX_W{1'b1}}) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Stage 1: accepted input plus synchronous bucket read
    // ---------------------------------------------------------------
    logic             s1_vld_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic [63:0]      s1_key_q;
    logic [63:0]      s1_rkey_q;
    logic [CNT_W-1:0] s1_rcnt_q;

    // Stage 2: update result; this is also the value written to the array
    logic             s2_vld_q;
    logic [IDX_W-1:0] s2_idx_q;
    logic [63:0]      s2_key_q;
    logic [CNT_W-1:0] s2_cnt_q;
    logic             s2_hit_q;
    logic             s2_evict_q;
    logic [63:0]      s2_old_q;

    // Bucket storage
    logic [63:0]      key_mem [DEPTH];
    logic [CNT_W-1:0] cnt_mem [DEPTH];

    // ---------------------------------------------------------------
    // Update rule, with bypass from the write landing on the same edge
    // as this input's read
    // ---------------------------------------------------------------
    logic             byp_c;
    logic [63:0]      cur_key_c;
    logic [CNT_W-1:0] cur_cnt_c;
    logic [63:0]      upd_key_c;
    logic [CNT_W-1:0] upd_cnt_c;
    logic             upd_hit_c;
    logic             upd_evict_c;
    logic [63:0]      upd_old_c;

    // Compute new bucket contents from the freshest bucket value
    always_comb begin
        byp_c       = s2_vld_q && (s2_idx_q == s1_idx_q);
        cur_key_c   = byp_c ? s2_key_q : s1_rkey_q;
        cur_cnt_c   = byp_c ? s2_cnt_q : s1_rcnt_q;
        upd_key_c   = s1_key_q;
        upd_cnt_c   = CNT_W'(1);
        upd_hit_c   = 1'b0;
        upd_evict_c = 1'b0;
        upd_old_c   = '0;
        if ((cur_cnt_c == '0) || (cur_key_c == s1_key_q)) begin
            upd_hit_c = 1'b1;
            upd_cnt_c = (cur_cnt_c == CNT_MAX) ? CNT_MAX : cur_cnt_c + CNT_W'(1);
        end else if (cur_cnt_c > CNT_W'(1)) begin
            upd_key_c = cur_key_c;
            upd_cnt_c = cur_cnt_c - CNT_W'(1);
        end else begin
            upd_evict_c = 1'b1;
            upd_old_c   = cur_key_c;
        end
    end

    // Array write port: zero sweep during init, pipeline update otherwise
    logic             mem_we_c;
    logic [IDX_W-1:0] mem_waddr_c;
    logic [63:0]      mem_wkey_c;
    logic [CNT_W-1:0] mem_wcnt_c;

    assign mem_we_c    = (state_q == ST_INIT) | s1_vld_q;
    assign mem_waddr_c = (state_q == ST_INIT) ? init_addr_q : s1_idx_q;
    assign mem_wkey_c  = (state_q == ST_INIT) ? 64'd0 : upd_key_c;
    assign mem_wcnt_c  = (state_q == ST_INIT) ? '0 : upd_cnt_c;

    // Bucket array write and synchronous read (contents cleared by the init sweep)
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            key_mem[mem_waddr_c] <= mem_wkey_c;
            cnt_mem[mem_waddr_c] <= mem_wcnt_c;
        end
        s1_rkey_q <= key_mem[in_idx_c];
        s1_rcnt_q <= cnt_mem[in_idx_c];
    end

    // Pipeline stages and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_vld_q    <= 1'b0;
            s1_idx_q    <= '0;
            s1_key_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_idx_q    <= '0;
            s2_key_q    <= '0;
            s2_cnt_q    <= '0;
            s2_hit_q    <= 1'b0;
            s2_evict_q  <= 1'b0;
            s2_old_q    <= '0;
            outvalid    <= 1'b0;
            out_idx     <= '0;
            out_key     <= '0;
            out_count   <= '0;
            out_hit     <= 1'b0;
            out_evict   <= 1'b0;
            out_old_key <= '0;
        end else begin
            s1_vld_q <= accept_c;
            if (accept_c) begin
                s1_idx_q <= in_idx_c;
                s1_key_q <= in_key_c;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_idx_q   <= s1_idx_q;
                s2_key_q   <= upd_key_c;
                s2_cnt_q   <= upd_cnt_c;
                s2_hit_q   <= upd_hit_c;
                s2_evict_q <= upd_evict_c;
                s2_old_q   <= upd_old_c;
            end
            outvalid <= s2_vld_q;
            if (s2_vld_q) begin
                out_idx     <= s2_idx_q;
                out_key     <= s2_key_q;
                out_count   <= s2_cnt_q;
                out_hit     <= s2_hit_q;
                out_evict   <= s2_evict_q;
                out_old_key <= s2_old_q;
            end
        end
    end

    assign ready = ready_q;

`ifdef SKETCH_STATS_EN
    logic [31:0] drop_q;
    logic [31:0] upd_q;

    // Statistics: dropped and accepted input counts, wrapping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_q <= '0;
            upd_q  <= '0;
        end else begin
            if (datavalid && !ready_q) drop_q <= drop_q + 32'd1;
            if (accept_c)              upd_q  <= upd_q + 32'd1;
        end
    end

    assign drop_cnt = drop_q;
    assign upd_cnt  = upd_q;
`else
    assign drop_cnt = 32'd0;
    assign upd_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_sketch_bucket_update.sv
// Scoreboard bench for sketch_bucket_update: a bucket-array reference model
// predicts each accepted input's result; a monitor compares on outvalid.
module tb_sketch_bucket_update;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;
`ifdef SKETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [95:0]      data_in;
    logic             datavalid;
    logic             ready;
    logic             outvalid;
    logic [IDX_W-1:0] out_idx;
    logic [63:0]      out_key;
    logic [CNT_W-1:0] out_count;
    logic             out_hit;
    logic             out_evict;
    logic [63:0]      out_old_key;
    logic [31:0]      drop_cnt;
    logic [31:0]      upd_cnt;

    sketch_bucket_update #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .datavalid(datavalid),
        .ready(ready), .outvalid(outvalid), .out_idx(out_idx), .out_key(out_key),
        .out_count(out_count), .out_hit(out_hit), .out_evict(out_evict),
        .out_old_key(out_old_key), .drop_cnt(drop_cnt), .upd_cnt(upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned      cyc;
        logic [IDX_W-1:0] idx;
        logic [63:0]      key;
        logic [CNT_W-1:0] cnt;
        logic             hit;
        logic             evict;
        logic [63:0]      old;
    } exp_t;

    exp_t        q[$];
    logic [63:0] m_key [DEPTH];
    int unsigned m_cnt [DEPTH];
    int unsigned m_drop;
    int unsigned m_upd;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: majority-vote bucket replacement
    task automatic model_apply(input int unsigned idx, input logic [63:0] key);
        exp_t        e;
        int unsigned c;
        c       = m_cnt[idx];
        e.cyc   = cyc + 3;
        e.idx   = IDX_W'(idx);
        e.hit   = 1'b0;
        e.evict = 1'b0;
        e.old   = 64'd0;
        if (c == 0 || m_key[idx] == key) begin
            m_key[idx] = key;
            m_cnt[idx] = (c < CMAX) ? c + 1 : CMAX;
            e.hit      = 1'b1;
        end else if (c > 1) begin
            m_cnt[idx] = c - 1;
        end else begin
            e.evict    = 1'b1;
            e.old      = m_key[idx];
            m_key[idx] = key;
            m_cnt[idx] = 1;
        end
        e.key = m_key[idx];
        e.cnt = CNT_W'(m_cnt[idx]);
        q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_key[i] = 64'd0;
            m_cnt[i] = 0;
        end
        m_drop = 0;
        m_upd  = 0;
        q.delete();
    endtask

    function automatic logic [95:0] mk_in(input int unsigned idx, input logic [63:0] key);
        logic [31:0] h;
        h = ($urandom() & 32'hFFFF_FFF0) | 32'(idx);
        return {h, key};
    endfunction

    // Called at a negedge; presents one input for the next rising edge
    task automatic send(input int unsigned idx, input logic [63:0] key);
        data_in   = mk_in(idx, key);
        datavalid = 1'b1;
        if (ready) begin
            m_upd++;
            model_apply(idx, key);
        end else begin
            m_drop++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        datavalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; one-cycle reset then wait for the init sweep
    task automatic do_reset(input bit do_drop);
        int n;
        reset_n   = 1'b0;
        datavalid = 1'b0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_outvalid", 64'(outvalid), 64'd0);
        chk("rst_out_key", out_key, 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_old_key", out_old_key, 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_upd_cnt", 64'(upd_cnt), 64'd0);
        n = 0;
        while (!ready && n < 100) begin
            if (n == 0 && do_drop) begin
                data_in   = mk_in(2, 64'h77);
                datavalid = 1'b1;
                m_drop++;
            end else begin
                datavalid = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        datavalid = 1'b0;
        chk("init_ready_len", 64'(n), 64'(DEPTH));
        chk("init_drop_cnt", 64'(drop_cnt), STATS ? 64'(m_drop) : 64'd0);
        chk("init_upd_cnt", 64'(upd_cnt), 64'd0);
    endtask

    // Monitor: compare every presented result against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (outvalid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_outvalid: got idx %0h key %0h want no result (cycle %0d)",
                             out_idx, out_key, cyc);
                end else begin
                    e = q.pop_front();
                    chk("latency", 64'(cyc), 64'(e.cyc));
                    chk("out_idx", 64'(out_idx), 64'(e.idx));
                    chk("out_key", out_key, e.key);
                    chk("out_count", 64'(out_count), 64'(e.cnt));
                    chk("out_hit", 64'(out_hit), 64'(e.hit));
                    chk("out_evict", 64'(out_evict), 64'(e.evict));
                    chk("out_old_key", out_old_key, e.old);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish by 500000");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned idx;
        logic [63:0] key;
        reset_n   = 1'b0;
        datavalid = 1'b0;
        data_in   = '0;
        model_clear();
        @(negedge clk);
        do_reset(1'b1);
        idle(2);

        // Back-to-back hits, then conflicts ending in an eviction
        repeat (3) send(3, 64'hA);
        repeat (3) send(3, 64'hB);
        idle(4);

        // Saturation
        repeat (5) send(5, 64'hC);
        idle(4);

        // Reset one cycle after an accepted input, then re-send it
        send(7, 64'hD);
        do_reset(1'b0);
        idle(1);
        send(7, 64'hD);
        idle(4);

        // Randomised traffic with a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset(1'b1);
            if ($urandom_range(0, 9) < 7) begin
                idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(0, DEPTH - 1);
                key = ($urandom_range(0, 15) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(1, 3));
                send(idx, key);
            end else begin
                idle(1);
            end
        end
        idle(5);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        chk("final_drop_cnt", 64'(drop_cnt), STATS ? 64'(m_drop) : 64'd0);
        chk("final_upd_cnt", 64'(upd_cnt), STATS ? 64'(m_upd) : 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
